lpc_reg_arb: RTL and testbench

LPC_REG_ARB -- requirements
Module: lpc_reg_arb

---
 rtl/lpc_pkg.sv | 23 ++
 rtl/lpc_wr_fifo.sv | 66 ++++++
 rtl/lpc_reg_arb.sv | 164 ++++++++++++++++
 tb/tb_lpc_reg_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC register-write arbiter.
//   arb_state_t      : arbiter state, equal to the source committed in the
//                      previous cycle (IDLE = nothing committed)
//   LPC_REG_COUNT    : default number of implemented registers
//   LPC_STARVE_LIMIT : default bound on back-to-back LPC commits while an
//                      internal request waits
//   addr_in_range()  : true when an address hits an implemented register
package lpc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LPC  = 2'd1,
    INT  = 2'd2
  } arb_state_t;

  localparam int LPC_REG_COUNT    = 32;
  localparam int LPC_STARVE_LIMIT = 4;

  function automatic logic addr_in_range(input logic [7:0] addr, input int reg_count);
    return int'({24'd0, addr}) < reg_count;
  endfunction

endpackage

// File: rtl/lpc_wr_fifo.sv
// Two-entry FIFO buffering host writes, each entry {addr, data}.
//   clk, rst_n : clock and synchronous active-low reset
//   push, din  : write an entry (ignored when full unless popping too)
//   pop, dout  : dout is the oldest entry; pop drops it (ignored when empty)
//   full/empty : occupancy flags
module lpc_wr_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty
);

  logic [15:0] mem_q [2];
  logic [15:0] mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only alongside a pop; the slot being
  // written is then the one being read out this cycle.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lpc_reg_arb.sv
// Arbitrates register-file writes between the LPC host and one internal
// requester. Host writes are never stalled: they are buffered in a 2-entry
// FIFO (or committed straight through when the FIFO is empty). The internal
// requester is guaranteed service after at most STARVE_LIMIT LPC commits.
//   LpcClock, PciReset      : clock, synchronous active-low reset
//   LpcWr/LpcAddr/LpcData   : host write strobe, address, data
//   IntReq/IntAddr/IntData  : internal request (held until IntGnt)
//   OvrClr                  : clears LpcOverrun
//   IntGnt/IntErr           : internal completion pulse / bad-address flag
//   RegWr/RegAddr/RegData   : registered register-file write port
//   Owner                   : source of the last commit (0 LPC, 1 internal)
//   LpcOverrun              : sticky "host write dropped" flag
module lpc_reg_arb
  import lpc_pkg::*;
#(
  parameter int STARVE_LIMIT = LPC_STARVE_LIMIT,
  parameter int REG_COUNT    = LPC_REG_COUNT
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LpcWr,
  input  logic [7:0] LpcAddr,
  input  logic [7:0] LpcData,
  input  logic       IntReq,
  input  logic [7:0] IntAddr,
  input  logic [7:0] IntData,
  input  logic       OvrClr,
  output logic       IntGnt,
  output logic       IntErr,
  output logic       RegWr,
  output logic [7:0] RegAddr,
  output logic [7:0] RegData,
  output logic       Owner,
  output logic       LpcOverrun
);

  localparam logic [2:0] STREAK_MAX = 3'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic [2:0]  streak_q, streak_d;
  logic        reg_wr_q, reg_wr_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        int_gnt_q, int_gnt_d;
  logic        int_err_q, int_err_d;
  logic        owner_q, owner_d;
  logic        overrun_q, overrun_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0] fifo_dout;
  logic        int_pending, lpc_avail, take_lpc, take_int;
  logic [7:0]  head_addr, head_data;

  lpc_wr_fifo u_fifo (
    .clk   (LpcClock),
    .rst_n (PciReset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({LpcAddr, LpcData}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The requester still holds IntReq during its grant cycle; that stale
  // level must not be seen as a second request.
  assign int_pending = IntReq && (state_q != INT);

  // An empty FIFO falls through to the live host write so a lone write
  // commits on the very next edge.
  assign lpc_avail = !fifo_empty || LpcWr;
  assign head_addr = fifo_empty ? LpcAddr : fifo_dout[15:8];
  assign head_data = fifo_empty ? LpcData : fifo_dout[7:0];

  assign take_lpc = lpc_avail && (!int_pending || (streak_q < STREAK_MAX));
  assign take_int = !take_lpc && int_pending;

  // Next-state, commit selection, FIFO control and overrun tracking.
  always_comb begin
    state_d    = IDLE;
    streak_d   = streak_q;
    reg_wr_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    int_gnt_d  = 1'b0;
    int_err_d  = 1'b0;
    owner_d    = owner_q;
    overrun_d  = overrun_q;
    fifo_pop   = 1'b0;
    fifo_push  = 1'b0;

    if (take_lpc) begin
      state_d  = LPC;
      owner_d  = 1'b0;
      fifo_pop = !fifo_empty;
      if (addr_in_range(head_addr, REG_COUNT)) begin
        reg_wr_d   = 1'b1;
        reg_addr_d = head_addr;
        reg_data_d = head_data;
      end
      if (int_pending && (streak_q < STREAK_MAX)) begin
        streak_d = streak_q + 3'd1;
      end
    end else if (take_int) begin
      state_d   = INT;
      owner_d   = 1'b1;
      int_gnt_d = 1'b1;
      streak_d  = 3'd0;
      if (addr_in_range(IntAddr, REG_COUNT)) begin
        reg_wr_d   = 1'b1;
        reg_addr_d = IntAddr;
        reg_data_d = IntData;
      end else begin
        int_err_d = 1'b1;
      end
    end

    if (!int_pending) begin
      streak_d = 3'd0;
    end

    // A host write consumed by the fall-through path is not also queued.
    fifo_push = LpcWr && !(take_lpc && fifo_empty) && (!fifo_full || fifo_pop);

    if (LpcWr && fifo_full && !fifo_pop) begin
      overrun_d = 1'b1;
    end else if (OvrClr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge LpcClock) begin
    if (!PciReset) begin
      state_q    <= IDLE;
      streak_q   <= 3'd0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= 8'd0;
      reg_data_q <= 8'd0;
      int_gnt_q  <= 1'b0;
      int_err_q  <= 1'b0;
      owner_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      reg_wr_q   <= reg_wr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      int_gnt_q  <= int_gnt_d;
      int_err_q  <= int_err_d;
      owner_q    <= owner_d;
      overrun_q  <= overrun_d;
    end
  end

  assign RegWr      = reg_wr_q;
  assign RegAddr    = reg_addr_q;
  assign RegData    = reg_data_q;
  assign IntGnt     = int_gnt_q;
  assign IntErr     = int_err_q;
  assign Owner      = owner_q;
  assign LpcOverrun = overrun_q;

endmodule

// File: tb/tb_lpc_reg_arb.sv
// Testbench for lpc_reg_arb: directed stimulus with a scoreboard queue of
// expected commits, drained by a monitor that samples on the falling edge.
module tb_lpc_reg_arb;

  logic       LpcClock = 1'b0;
  logic       PciReset = 1'b0;
  logic       LpcWr    = 1'b0;
  logic [7:0] LpcAddr  = 8'd0;
  logic [7:0] LpcData  = 8'd0;
  logic       IntReq   = 1'b0;
  logic [7:0] IntAddr  = 8'd0;
  logic [7:0] IntData  = 8'd0;
  logic       OvrClr   = 1'b0;
  logic       IntGnt, IntErr, RegWr, Owner, LpcOverrun;
  logic [7:0] RegAddr, RegData;

  typedef struct {
    bit         is_int;
    bit         err;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  lpc_reg_arb #(.STARVE_LIMIT(4), .REG_COUNT(32)) dut (
    .LpcClock   (LpcClock),
    .PciReset   (PciReset),
    .LpcWr      (LpcWr),
    .LpcAddr    (LpcAddr),
    .LpcData    (LpcData),
    .IntReq     (IntReq),
    .IntAddr    (IntAddr),
    .IntData    (IntData),
    .OvrClr     (OvrClr),
    .IntGnt     (IntGnt),
    .IntErr     (IntErr),
    .RegWr      (RegWr),
    .RegAddr    (RegAddr),
    .RegData    (RegData),
    .Owner      (Owner),
    .LpcOverrun (LpcOverrun)
  );

  always #15 LpcClock = ~LpcClock;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input bit is_int, input bit err, input logic [7:0] addr,
                          input logic [7:0] data);
    exp_t e;
    e.is_int = is_int;
    e.err    = err;
    e.addr   = addr;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's worth of inputs, then advance to just after the edge.
  task automatic apply_stimulus(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                                input logic ireq, input logic [7:0] iaddr,
                                input logic [7:0] idata, input logic clr);
    LpcWr   = wr;
    LpcAddr = addr;
    LpcData = data;
    IntReq  = ireq;
    IntAddr = iaddr;
    IntData = idata;
    OvrClr  = clr;
    @(posedge LpcClock);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_regwr"},   RegWr,      0);
    check_output({tag, "_intgnt"},  IntGnt,     0);
    check_output({tag, "_interr"},  IntErr,     0);
    check_output({tag, "_owner"},   Owner,      0);
    check_output({tag, "_overrun"}, LpcOverrun, 0);
    check_output({tag, "_regaddr"}, RegAddr,    0);
    check_output({tag, "_regdata"}, RegData,    0);
  endtask

  // Monitor: every visible commit must match the head of the scoreboard.
  always @(negedge LpcClock) begin
    exp_t e;
    if (RegWr === 1'b1 || IntGnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_commit: got RegWr=%0b IntGnt=%0b addr 0x%0h data 0x%0h, expected none",
                 RegWr, IntGnt, RegAddr, RegData);
      end else begin
        e = exp_q.pop_front();
        check_output("mon_intgnt", IntGnt, e.is_int);
        check_output("mon_interr", IntErr, e.err);
        check_output("mon_regwr",  RegWr,  !e.err);
        if (!e.err) begin
          check_output("mon_regaddr", RegAddr, e.addr);
          check_output("mon_regdata", RegData, e.data);
          check_output("mon_owner",   Owner,   e.is_int);
        end
      end
    end
  end

  // Internal request held high with a host write every cycle. Hand-traced
  // commit order (STARVE_LIMIT 4): w0-w3, INT, w4-w8, INT, w9-w13, INT,
  // w14, w15; the FIFO holds {w14,w15} when INT wins at cycle 16, so w16
  // is dropped.
  task automatic run_pattern(input bit with_reset);
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 8'(i), 8'(8'h80 + i));
    push_exp(1'b1, 1'b0, 8'h10, 8'h3C);
    for (int i = 4; i < 9; i++) push_exp(1'b0, 1'b0, 8'(i), 8'(8'h80 + i));
    push_exp(1'b1, 1'b0, 8'h10, 8'h3C);
    for (int i = 9; i < 14; i++) push_exp(1'b0, 1'b0, 8'(i), 8'(8'h80 + i));
    push_exp(1'b1, 1'b0, 8'h10, 8'h3C);
    if (!with_reset) begin
      push_exp(1'b0, 1'b0, 8'd14, 8'h8E);
      push_exp(1'b0, 1'b0, 8'd15, 8'h8F);
    end

    for (int i = 0; i <= 16; i++) begin
      if (i == 16) check_output("overrun_before_drop", LpcOverrun, 0);
      apply_stimulus(1'b1, 8'(i), 8'(8'h80 + i), 1'b1, 8'h10, 8'h3C,
                     (i == 16) && !with_reset);
    end

    if (with_reset) begin
      PciReset = 1'b0;
      idle();
      PciReset = 1'b1;
      repeat (4) idle();
      check_all_zero("after_midrun_reset");
    end else begin
      check_output("overrun_set_wins_over_clear", LpcOverrun, 1);
      apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
      check_output("overrun_cleared", LpcOverrun, 0);
      repeat (3) idle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) idle();
    check_all_zero("reset");
    PciReset = 1'b1;
    idle();

    // Single host write: commit one cycle later
    push_exp(1'b0, 1'b0, 8'h05, 8'hA5);
    apply_stimulus(1'b1, 8'h05, 8'hA5, 1'b0, 8'd0, 8'd0, 1'b0);
    check_output("lpc_latency_regwr", RegWr,   1);
    check_output("lpc_latency_addr",  RegAddr, 8'h05);
    check_output("lpc_latency_data",  RegData, 8'hA5);
    check_output("lpc_latency_owner", Owner,   0);
    idle();

    // Single internal request: grant one cycle later, not re-granted
    push_exp(1'b1, 1'b0, 8'h07, 8'h5A);
    apply_stimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'h07, 8'h5A, 1'b0);
    check_output("int_latency_gnt",   IntGnt, 1);
    check_output("int_latency_regwr", RegWr,  1);
    apply_stimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'h07, 8'h5A, 1'b0);
    check_output("int_no_regrant", IntGnt, 0);
    idle();

    // Internal out-of-range address: grant + error, no register write
    push_exp(1'b1, 1'b1, 8'h20, 8'h11);
    apply_stimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'h20, 8'h11, 1'b0);
    check_output("int_oor_err",   IntErr, 1);
    check_output("int_oor_regwr", RegWr,  0);
    apply_stimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'h20, 8'h11, 1'b0);
    idle();

    // Host out-of-range address dropped silently; last register still writable
    apply_stimulus(1'b1, 8'h40, 8'h77, 1'b0, 8'd0, 8'd0, 1'b0);
    check_output("lpc_oor_regwr", RegWr, 0);
    push_exp(1'b0, 1'b0, 8'h1F, 8'hC3);
    apply_stimulus(1'b1, 8'h1F, 8'hC3, 1'b0, 8'd0, 8'd0, 1'b0);
    check_output("lpc_top_addr_regwr", RegWr, 1);
    repeat (2) idle();

    // Starvation bound, overrun, set-over-clear, then clear
    run_pattern(1'b0);

    // Same traffic, reset while the FIFO is full
    run_pattern(1'b1);

    idle();
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
